// File: rtl/reg_bank_pkg.sv
// Shared types and access-type encodings for the parametrised register bank.
package reg_bank_pkg;

    // Bus handshake FSM: one access executes on the accepting edge, then one ack cycle.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    // Bit positions of the per-bit access-type vector used in the mask overlap check.
    localparam int unsigned ACC_RO  = 0;
    localparam int unsigned ACC_RW  = 1;
    localparam int unsigned ACC_RWE = 2;
    localparam int unsigned ACC_WO1 = 3;
    localparam int unsigned ACC_W1C = 4;
    localparam int unsigned ACC_NUM = 5;

    // Gather the access-type flags of one bit into a vector, one flag per type.
    function automatic logic [ACC_NUM-1:0] acc_vec(
        input logic ro,
        input logic rw,
        input logic rwe,
        input logic wo1,
        input logic w1c
    );
        logic [ACC_NUM-1:0] v;
        v          = '0;
        v[ACC_RO]  = ro;
        v[ACC_RW]  = rw;
        v[ACC_RWE] = rwe;
        v[ACC_WO1] = wo1;
        v[ACC_W1C] = w1c;
        return v;
    endfunction

endpackage

// File: rtl/reg_bank_reg.sv
// One DW-bit register of the bank. Each bit follows the access type given by
// its mask; bits in no mask are constant INIT. RO bits are passed through
// combinationally from ro_data_i.
module reg_bank_reg
    import reg_bank_pkg::*;
#(
    parameter int            DW       = 16,
    parameter logic [DW-1:0] RO_MASK  = '0,
    parameter logic [DW-1:0] RW_MASK  = '0,
    parameter logic [DW-1:0] RWE_MASK = '0,
    parameter logic [DW-1:0] WO1_MASK = '0,
    parameter logic [DW-1:0] W1C_MASK = '0,
    parameter logic [DW-1:0] INIT     = '0
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rwe_write_i,
    input  logic [DW-1:0] rwe_data_i,
    input  logic [DW-1:0] ro_data_i,
    input  logic [DW-1:0] hw_set_i,
    output logic [DW-1:0] q_o,
    output logic          w1c_pend_o
);

    localparam logic [DW-1:0] STORE_MASK = RW_MASK | RWE_MASK | WO1_MASK | W1C_MASK;
    localparam logic [DW-1:0] CONST_MASK = ~(STORE_MASK | RO_MASK);

    logic [DW-1:0] stor_q, stor_d;
    logic          wo_done_q, wo_done_d;
    logic [DW-1:0] rw_nxt, rwe_nxt, wo1_nxt, w1c_nxt;

    // Per-type next value; the masks pick which candidate each bit takes.
    always_comb begin
        rw_nxt    = wr_en_i ? wdata_i : stor_q;
        // Hardware load beats a simultaneous bus write.
        rwe_nxt   = rwe_write_i ? rwe_data_i : rw_nxt;
        wo1_nxt   = (wr_en_i && !wo_done_q) ? wdata_i : stor_q;
        // Set is OR-ed last so it wins over a simultaneous clear.
        w1c_nxt   = (wr_en_i ? (stor_q & ~wdata_i) : stor_q) | hw_set_i;
        stor_d    = (rw_nxt  & RW_MASK)  |
                    (rwe_nxt & RWE_MASK) |
                    (wo1_nxt & WO1_MASK) |
                    (w1c_nxt & W1C_MASK) |
                    (INIT    & ~STORE_MASK);
        // Any write closes the write-once window until the next reset.
        wo_done_d = wo_done_q | wr_en_i;
    end

    // Stored bits and write-once flag.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stor_q    <= INIT;
            wo_done_q <= 1'b0;
        end else begin
            stor_q    <= stor_d;
            wo_done_q <= wo_done_d;
        end
    end

    // Visible value: stored bits, live RO bits, constant bits.
    always_comb begin
        q_o        = (stor_q & STORE_MASK) | (ro_data_i & RO_MASK) | (INIT & CONST_MASK);
        w1c_pend_o = |(stor_q & W1C_MASK);
    end

endmodule

// File: rtl/reg_bank.sv
// Addressed register bank: NREGS registers of DW bits behind a req/ack bus.
// Holds the handshake FSM, address decode, registered read data and irq.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int                  NREGS    = 4,
    parameter int                  DW       = 16,
    parameter int                  AW       = (NREGS > 1) ? $clog2(NREGS) : 1,
    parameter logic [NREGS*DW-1:0] RO_MASK  = '0,
    parameter logic [NREGS*DW-1:0] RW_MASK  = '0,
    parameter logic [NREGS*DW-1:0] RWE_MASK = '0,
    parameter logic [NREGS*DW-1:0] WO1_MASK = '0,
    parameter logic [NREGS*DW-1:0] W1C_MASK = '0,
    parameter logic [NREGS*DW-1:0] INIT     = '0
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                req,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       wdata,
    output logic                ack,
    output logic                err,
    output logic [DW-1:0]       rdata,
    input  logic [NREGS-1:0]    rwe_write,
    input  logic [NREGS*DW-1:0] rwe_data,
    input  logic [NREGS*DW-1:0] ro_data,
    input  logic [NREGS*DW-1:0] hw_set,
    output logic [NREGS*DW-1:0] q,
    output logic                irq
);

    // A bit may carry at most one access type.
    for (genvar b = 0; b < NREGS*DW; b++) begin : g_chk
        if ($countones(acc_vec(RO_MASK[b], RW_MASK[b], RWE_MASK[b],
                               WO1_MASK[b], W1C_MASK[b])) > 1) begin : g_err
            $error("reg_bank: bit %0d has more than one access type", b);
        end
    end

    state_t              state_q, state_d;
    logic                err_q;
    logic [DW-1:0]       rdata_q;
    logic                irq_q;
    logic                accept;
    logic                addr_ok;
    logic                wr_acc;
    logic [DW-1:0]       rd_sel;
    logic [NREGS-1:0]    w1c_pend;

    assign accept  = (state_q == IDLE) && req;
    assign addr_ok = int'(addr) < NREGS;
    assign wr_acc  = accept && we && addr_ok;

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        reg_bank_reg #(
            .DW      (DW),
            .RO_MASK (RO_MASK [r*DW +: DW]),
            .RW_MASK (RW_MASK [r*DW +: DW]),
            .RWE_MASK(RWE_MASK[r*DW +: DW]),
            .WO1_MASK(WO1_MASK[r*DW +: DW]),
            .W1C_MASK(W1C_MASK[r*DW +: DW]),
            .INIT    (INIT    [r*DW +: DW])
        ) u_reg (
            .clk        (clk),
            .rstb       (rstb),
            .wr_en_i    (wr_acc && (int'(addr) == r)),
            .wdata_i    (wdata),
            .rwe_write_i(rwe_write[r]),
            .rwe_data_i (rwe_data[r*DW +: DW]),
            .ro_data_i  (ro_data [r*DW +: DW]),
            .hw_set_i   (hw_set  [r*DW +: DW]),
            .q_o        (q       [r*DW +: DW]),
            .w1c_pend_o (w1c_pend[r])
        );
    end

    // Read mux: pre-update register value at the addressed slot.
    always_comb begin
        rd_sel = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (int'(addr) == r) begin
                rd_sel = q[r*DW +: DW];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a request is taken only in IDLE, ACK always returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: response is shown only during ACK, zero otherwise.
    always_comb begin
        ack   = (state_q == ACK);
        err   = ack && err_q;
        rdata = ack ? rdata_q : '0;
    end

    // Response captured on the accepting edge; writes and bad addresses return 0.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            err_q   <= !addr_ok;
            rdata_q <= (!we && addr_ok) ? rd_sel : '0;
        end
    end

    // Interrupt is the registered OR of every status bit.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |w1c_pend;
        end
    end

    assign irq = irq_q;

endmodule
